// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: word width, line rate, system clock and the
// receiver-to-FIFO handshake bundle.
package uart_rx_fifo_pkg;

    localparam int UART_PAYLOAD_BITS  = 8;
    localparam int UART_BIT_RATE      = 9600;
    localparam int UART_CLK_HZ        = 50_000_000;
    localparam int UART_RX_FIFO_DEPTH = 16;

    // One receiver output beat. A beat with brk set carries no data.
    typedef struct packed {
        logic                         valid;
        logic                         brk;
        logic [UART_PAYLOAD_BITS-1:0] data;
    } uart_rx_bundle_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register file backing the receive FIFO: one synchronous write port and
// one combinational read port so the FIFO head is visible without latency.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; the FIFO pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side show-ahead byte queue with sticky overflow and BREAK flags.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int PAYLOAD_BITS = UART_PAYLOAD_BITS,
    parameter int DEPTH        = UART_RX_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_valid,
    input  logic [PAYLOAD_BITS-1:0]     rx_data,
    input  logic                        rx_break,
    input  logic                        rd_en,
    output logic [PAYLOAD_BITS-1:0]     rd_data,
    output logic                        rd_valid,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow,
    output logic                        break_seen,
    input  logic                        clr_flags
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    logic [ADDR_W:0]       wr_ptr_reg;
    logic [ADDR_W:0]       rd_ptr_reg;
    logic [ADDR_W:0]       level_reg;
    logic                  overflow_reg;
    logic                  break_seen_reg;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  data_beat;
    logic [PAYLOAD_BITS-1:0] mem_rd_data;

    // Pointer comparison: equal means empty, equal index with opposite wrap bit means full.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                   (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);

    // A BREAK beat never carries data, so it is excluded from push and drop alike.
    assign data_beat = rx_valid & ~rx_break;
    assign pop       = rd_en & ~empty;
    assign push      = data_beat & (~full | pop);
    assign drop      = data_beat & full & ~pop;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (PAYLOAD_BITS)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
        .wr_data (rx_data),
        .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
        .rd_data (mem_rd_data)
    );

    // Pointer and occupancy bookkeeping; level moves by at most one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + PTR_ONE;
                2'b01:   level_reg <= level_reg - PTR_ONE;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as clr_flags takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg   <= 1'b0;
            break_seen_reg <= 1'b0;
        end else begin
            overflow_reg   <= drop     | (overflow_reg   & ~clr_flags);
            break_seen_reg <= rx_break | (break_seen_reg & ~clr_flags);
        end
    end

    assign rd_data    = empty ? '0 : mem_rd_data;
    assign rd_valid   = ~empty;
    assign level      = level_reg;
    assign overflow   = overflow_reg;
    assign break_seen = break_seen_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: each step drives strobes for one clock,
// then compares outputs 1 ns after the edge against hand-computed values.
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            rd_en;
    logic            clr_flags;
    uart_rx_bundle_t stim;
    logic [7:0]      rd_data;
    logic            rd_valid;
    logic [4:0]      level;
    logic            full;
    logic            empty;
    logic            overflow;
    logic            break_seen;

    int n_cmp = 0;
    int n_mis = 0;

    uart_rx_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (stim.valid),
        .rx_data    (stim.data),
        .rx_break   (stim.brk),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .break_seen (break_seen),
        .clr_flags  (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) begin
            $display("check %-14s obs=%0h", tag, obs);
        end else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply current inputs across one rising edge, then drop all strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        stim      = '0;
        rd_en     = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        stim.valid = 1'b1;
        stim.data  = d;
        tick();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
    endtask

    initial begin
        stim      = '0;
        rd_en     = 1'b0;
        clr_flags = 1'b0;
        rst_n     = 1'b0;
        #3;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_break", break_seen, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: two pushes then one pop
        push(8'hA5);
        chk("t1_first_vis", rd_data, 8'hA5);
        push(8'h3C);
        chk("t1_head", rd_data, 8'hA5);
        chk("t1_level2", level, 2);
        pop();
        chk("t1_pop_data", rd_data, 8'h3C);
        chk("t1_level1", level, 1);
        pop();
        chk("t1_empty", empty, 1);

        // 2: fill to DEPTH, overflow on the 17th word, drain in order
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("t2_full", full, 1);
        chk("t2_level16", level, 16);
        chk("t2_no_ovf_yet", overflow, 0);
        push(8'hFF);
        chk("t2_overflow", overflow, 1);
        chk("t2_level_hold", level, 16);
        chk("t2_full_hold", full, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_pop%0d", i), rd_data, 32'(i));
            pop();
        end
        chk("t2_drained", empty, 1);
        chk("t2_rd_zero", rd_data, 0);
        clr_flags = 1'b1;
        tick();
        chk("t2_ovf_clr", overflow, 0);

        // 3: push and pop together while full
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        chk("t3_full", full, 1);
        stim.valid = 1'b1;
        stim.data  = 8'h77;
        rd_en      = 1'b1;
        tick();
        chk("t3_no_ovf", overflow, 0);
        chk("t3_level16", level, 16);
        chk("t3_full", full, 1);
        chk("t3_head", rd_data, 8'h21);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("t3_pop%0d", i), rd_data, 32'(8'h21 + i));
            pop();
        end
        chk("t3_last_77", rd_data, 8'h77);
        chk("t3_level1", level, 1);
        pop();
        chk("t3_empty", empty, 1);

        // 4: push and pop together while empty
        stim.valid = 1'b1;
        stim.data  = 8'h11;
        rd_en      = 1'b1;
        tick();
        chk("t4_level1", level, 1);
        chk("t4_data", rd_data, 8'h11);
        chk("t4_rd_valid", rd_valid, 1);
        pop();
        chk("t4_empty", empty, 1);

        // 5: BREAK beat is not stored; set beats clear
        stim.valid = 1'b1;
        stim.brk   = 1'b1;
        stim.data  = 8'h00;
        tick();
        chk("t5_break", break_seen, 1);
        chk("t5_level0", level, 0);
        chk("t5_empty", empty, 1);
        stim.brk  = 1'b1;
        clr_flags = 1'b1;
        tick();
        chk("t5_set_wins", break_seen, 1);
        clr_flags = 1'b1;
        tick();
        chk("t5_cleared", break_seen, 0);

        // 6: asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
        stim.brk = 1'b1;
        tick();
        chk("t6_level5", level, 5);
        chk("t6_break", break_seen, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_empty", empty, 1);
        chk("t6_level0", level, 0);
        chk("t6_rd_zero", rd_data, 0);
        chk("t6_break_clr", break_seen, 0);
        chk("t6_ovf_clr", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        push(8'h9E);
        chk("t6_after_rst", rd_data, 8'h9E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
